lsu_ctrl: RTL and testbench



---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 60 ++++++
 rtl/lsu_ctrl.sv | 129 ++++++++++++
 tb/tb_lsu_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and access-decoding helpers for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths only make sense for loads.
    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// extraction plus sign/zero extension of load data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be         = 4'b0000;
        wdata_lane = '0;
        case (funct3[1:0])
            2'b00: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    always_comb begin
        byte_sel = rdata[7:0];
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        load_data = '0;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_W:    load_data = rdata;
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding load/store controller driving a word-wide RAM with
// byte enables and a one-cycle registered read.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    if (MEM_LAT != 1) begin : g_bad_mem_lat
        $error("lsu_ctrl: MEM_LAT must be 1");
    end

    state_t     state;
    logic       we_q;
    logic [2:0] funct3_q;
    logic [1:0] addr_lo_q;

    logic [2:0]  align_funct3;
    logic [1:0]  align_addr_lo;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        req_bad;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both high; req_ready is high exactly in IDLE. The
    // response is a single-cycle rsp_valid strobe with no backpressure.
    assign req_ready = (state == IDLE);

    // In IDLE the aligner steers the incoming store; afterwards it extracts
    // load data for the captured access.
    assign align_funct3  = (state == IDLE) ? req_funct3    : funct3_q;
    assign align_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_lo_q;

    assign req_bad = !is_legal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);

    lsu_lane_align u_align (
        .funct3     (align_funct3),
        .addr_lo    (align_addr_lo),
        .rdata      (mem_rdata),
        .wdata      (req_wdata),
        .be         (align_be),
        .wdata_lane (align_wdata),
        .load_data  (align_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        addr_lo_q <= req_addr[1:0];
                        if (req_bad) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RESP;
                        end else begin
                            mem_en    <= 1'b1;
                            mem_we    <= req_we;
                            mem_be    <= req_we ? align_be : 4'b1111;
                            mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata <= req_we ? align_wdata : 32'd0;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (we_q) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= align_load;
                    state     <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, multi-cycle sequences and
// random traffic checked against a byte-array memory model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    lsu_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: 16 words starting at 0x10000, registered read.
    logic [31:0] ram [16];
    int          write_cnt = 0;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int j = 0; j < 4; j++)
                    if (mem_be[j]) ram[mem_addr[5:2]][8*j +: 8] <= mem_wdata[8*j +: 8];
                write_cnt <= write_cnt + 1;
            end else begin
                mem_rdata <= ram[mem_addr[5:2]];
            end
        end
    end

    // Reference memory: plain byte array for the same 64-byte window.
    logic [7:0] ref_mem [64];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_is_err(input logic we, input logic [2:0] f3, input int off);
        int n = size_of(f3);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (we && f3[2]) return 1'b1;
        if (n == 2 && (off % 2) != 0) return 1'b1;
        if (n == 4 && (off % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input int off, input logic [2:0] f3);
        int n = size_of(f3);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[off+i];
        if (!f3[2] && n < 4 && v[8*n-1])
            for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic ref_store(input int off, input logic [2:0] f3, input logic [31:0] wd);
        int n = size_of(f3);
        for (int i = 0; i < n; i++) ref_mem[off+i] = wd[8*i +: 8];
    endtask

    function automatic logic [3:0] ref_be(input int off, input logic [2:0] f3);
        logic [3:0] be = '0;
        for (int i = 0; i < size_of(f3); i++) be[(off % 4) + i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [2:0] f3, input logic [31:0] wd);
        int n = size_of(f3);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[8*j +: 8] = wd[8*(j % n) +: 8];
        return w;
    endfunction

    // Observed transaction fields filled in by send().
    int          g_lat;
    int          g_en;
    logic        g_we;
    logic [3:0]  g_be;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [31:0] g_rdata;
    logic        g_err;
    logic        g_rdy_resp;

    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        int guard = 0;
        while (!req_ready && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        req_we     = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        g_lat = 1;
        g_en  = 0;
        g_we = 1'bx; g_be = 'x; g_addr = 'x; g_wdata = 'x;
        while (!rsp_valid && g_lat < 8) begin
            if (mem_en) begin
                g_en++;
                g_we = mem_we; g_be = mem_be; g_addr = mem_addr; g_wdata = mem_wdata;
            end
            @(negedge clk);
            g_lat++;
        end
        if (mem_en) g_en++;
        g_rdata    = rsp_rdata;
        g_err      = rsp_err;
        g_rdy_resp = req_ready;
        @(negedge clk);
        chk("strobe_one_cycle", rsp_valid, 1'b0);
        chk("rdata_idle_zero", rsp_rdata, 32'd0);
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [31:0] addr,
                             input logic e_err, input logic [31:0] e_rdata, input int e_lat,
                             input logic [3:0] e_be, input logic [31:0] e_wdata);
        chk($sformatf("%s latency", tag), g_lat, e_lat);
        chk($sformatf("%s err", tag), g_err, e_err);
        chk($sformatf("%s rdata", tag), g_rdata, e_rdata);
        chk($sformatf("%s mem_en_cycles", tag), g_en, e_err ? 0 : 1);
        chk($sformatf("%s ready_in_resp", tag), g_rdy_resp, 1'b0);
        if (!e_err) begin
            chk($sformatf("%s mem_we", tag), g_we, we);
            chk($sformatf("%s mem_be", tag), g_be, e_be);
            chk($sformatf("%s mem_addr", tag), g_addr, addr & 32'hFFFF_FFFC);
            chk($sformatf("%s mem_wdata", tag), g_wdata, e_wdata);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [3:0]  be;
        logic [31:0] mwd;
    } vec_t;

    vec_t tbl[15];

    task automatic check_outputs_reset(input string tag);
        chk({tag, " req_ready"}, req_ready, 1'b1);
        chk({tag, " rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " rsp_err"}, rsp_err, 1'b0);
        chk({tag, " mem_en"}, mem_en, 1'b0);
        chk({tag, " mem_we"}, mem_we, 1'b0);
        chk({tag, " mem_be"}, mem_be, 4'd0);
        chk({tag, " mem_addr"}, mem_addr, 32'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr, wd, e_rd, old_word;
        int          off, wc0, n_acc, n_rsp, drop;
        int          acc_cyc[3];
        int          rsp_cyc[3];
        logic        e_err;

        for (int i = 0; i < 16; i++) ram[i] = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        mem_rdata  = '0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = '0;

        // clock/reset
        #1;
        check_outputs_reset("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors
        tbl[0]  = '{1'b1, 3'b010, 32'h10000, 32'hDEADBEEF, 1'b0, 32'h0,        2, 4'b1111, 32'hDEADBEEF};
        tbl[1]  = '{1'b1, 3'b000, 32'h10003, 32'h0000005A, 1'b0, 32'h0,        2, 4'b1000, 32'h5A5A5A5A};
        tbl[2]  = '{1'b0, 3'b010, 32'h10000, 32'h0,        1'b0, 32'h5AADBEEF, 3, 4'b1111, 32'h0};
        tbl[3]  = '{1'b1, 3'b010, 32'h10000, 32'h80FF7F01, 1'b0, 32'h0,        2, 4'b1111, 32'h80FF7F01};
        tbl[4]  = '{1'b0, 3'b000, 32'h10002, 32'h0,        1'b0, 32'hFFFFFFFF, 3, 4'b1111, 32'h0};
        tbl[5]  = '{1'b0, 3'b100, 32'h10002, 32'h0,        1'b0, 32'h000000FF, 3, 4'b1111, 32'h0};
        tbl[6]  = '{1'b0, 3'b001, 32'h10002, 32'h0,        1'b0, 32'hFFFF80FF, 3, 4'b1111, 32'h0};
        tbl[7]  = '{1'b0, 3'b101, 32'h10000, 32'h0,        1'b0, 32'h00007F01, 3, 4'b1111, 32'h0};
        tbl[8]  = '{1'b0, 3'b010, 32'h10001, 32'h0,        1'b1, 32'h0,        1, 4'b0000, 32'h0};
        tbl[9]  = '{1'b1, 3'b001, 32'h10003, 32'h1234,     1'b1, 32'h0,        1, 4'b0000, 32'h0};
        tbl[10] = '{1'b0, 3'b011, 32'h10000, 32'h0,        1'b1, 32'h0,        1, 4'b0000, 32'h0};
        tbl[11] = '{1'b1, 3'b100, 32'h10000, 32'h77,       1'b1, 32'h0,        1, 4'b0000, 32'h0};
        tbl[12] = '{1'b1, 3'b001, 32'h10006, 32'h0000ABCD, 1'b0, 32'h0,        2, 4'b1100, 32'hABCDABCD};
        tbl[13] = '{1'b0, 3'b001, 32'h10006, 32'h0,        1'b0, 32'hFFFFABCD, 3, 4'b1111, 32'h0};
        tbl[14] = '{1'b0, 3'b000, 32'h10007, 32'h0,        1'b0, 32'hFFFFFFAB, 3, 4'b1111, 32'h0};

        for (int k = 0; k < 15; k++) begin
            send(tbl[k].we, tbl[k].f3, tbl[k].addr, tbl[k].wd);
            check_txn($sformatf("vec%0d", k), tbl[k].we, tbl[k].addr, tbl[k].err,
                      tbl[k].rdata, tbl[k].lat, tbl[k].be, tbl[k].mwd);
            if (tbl[k].we && !tbl[k].err)
                ref_store(int'(tbl[k].addr - 32'h10000), tbl[k].f3, tbl[k].wd);
        end

        // back-to-back LW with req_valid held high
        e_rd = ref_load(0, 3'b010);
        n_acc = 0; n_rsp = 0; drop = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10000; req_wdata = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (drop != 0) req_valid = 1'b0;
            if (rsp_valid) begin
                chk("b2b ready_low_in_resp", req_ready, 1'b0);
                chk("b2b rdata", rsp_rdata, e_rd);
                if (n_rsp < 3) rsp_cyc[n_rsp] = cyc;
                n_rsp++;
            end
            if (req_valid && req_ready && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 3) drop = 1;
            end
        end
        chk("b2b accepts", n_acc, 3);
        chk("b2b responses", n_rsp, 3);
        if (n_acc == 3 && n_rsp == 3) begin
            chk("b2b spacing01", acc_cyc[1] - acc_cyc[0], 4);
            chk("b2b spacing12", acc_cyc[2] - acc_cyc[1], 4);
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b rsp%0d latency", i), rsp_cyc[i] - acc_cyc[i], 3);
        end

        // random traffic against the reference model
        for (int k = 0; k < 200; k++) begin
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            off  = int'($urandom_range(0, 63));
            addr = 32'h10000 + 32'(off);
            wd   = $urandom;
            e_err = ref_is_err(we, f3, off);
            send(we, f3, addr, wd);
            if (e_err) begin
                check_txn($sformatf("rnd%0d", k), we, addr, 1'b1, 32'h0, 1, 4'b0, 32'h0);
            end else if (we) begin
                check_txn($sformatf("rnd%0d", k), we, addr, 1'b0, 32'h0, 2,
                          ref_be(off, f3), ref_lanes(f3, wd));
                ref_store(off, f3, wd);
            end else begin
                check_txn($sformatf("rnd%0d", k), we, addr, 1'b0, ref_load(off, f3), 3,
                          4'b1111, 32'h0);
            end
        end

        // reset during the ISSUE cycle of a store
        @(negedge clk);
        wc0 = write_cnt;
        old_word = ram[8];
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10020; req_wdata = ~old_word;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst issue mem_en", mem_en, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check_outputs_reset("async_rst");
        @(posedge clk);
        @(negedge clk);
        chk("rst no_write_count", write_cnt, wc0);
        chk("rst ram_unchanged", ram[8], old_word);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst ready_after", req_ready, 1'b1);
        chk("rst rsp_valid_after", rsp_valid, 1'b0);
        send(1'b0, 3'b010, 32'h10020, 32'h0);
        check_txn("post_rst_lw", 1'b0, 32'h10020, 1'b0, ref_load(32, 3'b010), 3, 4'b1111, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
